rf_write_arbiter: RTL and testbench

// - Shares the register file's single write port (A3/WD3/WE3) between two writeback requesters.
// - Port 0 is the ALU writeback and has default priority; port 1 is the load/memory writeback.
// - Port 1 is protected by an anti-starvation counter.
// - Sits between the writeback stage(s) and reg_file; output is registered, with one-cycle latency.

---
 rtl/rf_arb_pkg.sv | 11 +
 rtl/rf_write_arbiter.sv | 111 +++++++++++
 tb/tb_rf_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

   typedef enum logic {S_P0PRI, S_P1FORCE} arb_state_t;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;

   localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

endpackage : rf_arb_pkg

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the ALU writeback (port 0)
// and the load writeback (port 1), with anti-starvation forcing for port 1.
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
   parameter int unsigned DATA_WIDTH = RF_DATA_W,
   parameter int unsigned MAX_WAIT   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_valid,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_data,
   output logic                  p0_ready,
   input  logic                  p1_valid,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_data,
   output logic                  p1_ready,
   output logic [ADDR_WIDTH-1:0] A3,
   output logic [DATA_WIDTH-1:0] WD3,
   output logic                  WE3,
   output logic                  conflict
);

   localparam int unsigned          CNT_W     = 4;
   localparam logic [CNT_W-1:0]     WAIT_MAX  = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0]     WAIT_LAST = CNT_W'(MAX_WAIT - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(REG_ZERO);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_cnt_nxt;

   logic w_p0_nz;
   logic w_p1_nz;
   logic w_p0_grant;
   logic w_p1_grant;
   logic w_p1_denied;

   // Grant logic: register-0 writes are acknowledged without using the slot
   always_comb begin
      w_p0_nz     = p0_valid && (p0_addr != ADDR_ZERO);
      w_p1_nz     = p1_valid && (p1_addr != ADDR_ZERO);
      w_p0_grant  = 1'b0;
      w_p1_grant  = 1'b0;
      if (!rst) begin
         if (r_state == S_P1FORCE) begin
            w_p1_grant = w_p1_nz;
            w_p0_grant = w_p0_nz && !w_p1_nz;
         end else begin
            w_p0_grant = w_p0_nz;
            w_p1_grant = w_p1_nz && !w_p0_nz;
         end
      end
      p0_ready    = !rst && p0_valid && (!w_p0_nz || w_p0_grant);
      p1_ready    = !rst && p1_valid && (!w_p1_nz || w_p1_grant);
      w_p1_denied = !rst && w_p1_nz && !w_p1_grant;
   end

   // Starvation counter and priority FSM next-state
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;

      if (!p1_valid || p1_ready) begin
         w_wait_cnt_nxt = '0;
      end else if (w_p1_denied && (r_wait_cnt != WAIT_MAX)) begin
         w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
      end

      case (r_state)
         S_P0PRI: begin
            if (w_p1_denied && (r_wait_cnt == WAIT_LAST)) begin
               w_state_nxt = S_P1FORCE;
            end
         end
         S_P1FORCE: begin
            if (p1_ready || !p1_valid) begin
               w_state_nxt = S_P0PRI;
            end
         end
         default: w_state_nxt = S_P0PRI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_P0PRI;
         r_wait_cnt <= '0;
         WE3        <= 1'b0;
         A3         <= '0;
         WD3        <= '0;
         conflict   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         WE3        <= w_p0_grant || w_p1_grant;
         conflict   <= w_p0_nz && w_p1_nz;
         if (w_p1_grant) begin
            A3  <= p1_addr;
            WD3 <= p1_data;
         end else if (w_p0_grant) begin
            A3  <= p0_addr;
            WD3 <= p0_data;
         end
      end
   end

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a randomized
// run checked against a streak-based priority model.
module tb_rf_write_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = 3;

   logic          clk;
   logic          rst;
   logic          p0_valid;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_data;
   logic          p0_ready;
   logic          p1_valid;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_data;
   logic          p1_ready;
   logic [AW-1:0] A3;
   logic [DW-1:0] WD3;
   logic          WE3;
   logic          conflict;

   int checks;
   int failures;

   rf_write_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MAX_WAIT   (MW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .p0_valid (p0_valid),
      .p0_addr  (p0_addr),
      .p0_data  (p0_data),
      .p0_ready (p0_ready),
      .p1_valid (p1_valid),
      .p1_addr  (p1_addr),
      .p1_data  (p1_data),
      .p1_ready (p1_ready),
      .A3       (A3),
      .WD3      (WD3),
      .WE3      (WE3),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   // Apply inputs just after the falling edge and let combinational outputs settle
   task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      @(negedge clk);
      p0_valid = v0; p0_addr = a0; p0_data = d0;
      p1_valid = v1; p1_addr = a1; p1_data = d1;
      #1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 5'd3, 32'h1111, 1'b1, 5'd4, 32'h2222);
         checks++;
         if (p0_ready !== 1'b0) begin failures++; $display("FAIL reset_p0_ready got=%b exp=0", p0_ready); end
         checks++;
         if (p1_ready !== 1'b0) begin failures++; $display("FAIL reset_p1_ready got=%b exp=0", p1_ready); end
      end
      after_edge();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      rst = 1'b0;
      checks++;
      if (WE3 !== 1'b0) begin failures++; $display("FAIL reset_we3 got=%b exp=0", WE3); end
      checks++;
      if (A3 !== '0) begin failures++; $display("FAIL reset_a3 got=%h exp=0", A3); end
      checks++;
      if (WD3 !== '0) begin failures++; $display("FAIL reset_wd3 got=%h exp=0", WD3); end
      checks++;
      if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
   endtask

   task automatic test_p0_alone();
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
      checks++;
      if (p0_ready !== 1'b1) begin failures++; $display("FAIL p0_alone_ready got=%b exp=1", p0_ready); end
      after_edge();
      checks++;
      if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
         failures++; $display("FAIL p0_alone_write got we=%b a=%0d d=%h exp we=1 a=5 d=deadbeef", WE3, A3, WD3);
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      after_edge();
      checks++;
      if (WE3 !== 1'b0 || A3 !== 5'd5) begin
         failures++; $display("FAIL p0_alone_idle got we=%b a=%0d exp we=0 a=5", WE3, A3);
      end
   endtask

   task automatic test_starvation();
      logic [AW-1:0] a0;
      logic [DW-1:0] d1;
      logic          exp_p1;
      a0 = 5'd1;
      d1 = 32'h100;
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, a0, 32'(a0) + 32'hA000, 1'b1, 5'd8, d1);
         exp_p1 = (i == 3);
         checks++;
         if (p0_ready !== !exp_p1 || p1_ready !== exp_p1) begin
            failures++; $display("FAIL starve_grant cyc=%0d got r0=%b r1=%b exp r0=%b r1=%b", i, p0_ready, p1_ready, !exp_p1, exp_p1);
         end
         after_edge();
         checks++;
         if (WE3 !== 1'b1 || A3 !== (exp_p1 ? 5'd8 : a0) || WD3 !== (exp_p1 ? d1 : 32'(a0) + 32'hA000)) begin
            failures++; $display("FAIL starve_write cyc=%0d got we=%b a=%0d d=%h", i, WE3, A3, WD3);
         end
         checks++;
         if (conflict !== 1'b1) begin failures++; $display("FAIL starve_conflict cyc=%0d got=%b exp=1", i, conflict); end
         if (exp_p1) d1 = d1 + 32'd1;
         else        a0 = a0 + AW'(1);
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      after_edge();
   endtask

   task automatic test_zero_addr();
      drive(1'b1, 5'd0, 32'h77, 1'b1, 5'd7, 32'h55);
      checks++;
      if (p0_ready !== 1'b1 || p1_ready !== 1'b1) begin
         failures++; $display("FAIL zero_ready got r0=%b r1=%b exp r0=1 r1=1", p0_ready, p1_ready);
      end
      after_edge();
      checks++;
      if (WE3 !== 1'b1 || A3 !== 5'd7 || WD3 !== 32'h55) begin
         failures++; $display("FAIL zero_write got we=%b a=%0d d=%h exp we=1 a=7 d=55", WE3, A3, WD3);
      end
      checks++;
      if (conflict !== 1'b0) begin failures++; $display("FAIL zero_conflict got=%b exp=0", conflict); end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      after_edge();
      checks++;
      if (WE3 !== 1'b0) begin failures++; $display("FAIL zero_single_pulse got we=%b exp=0", WE3); end
   endtask

   task automatic test_same_addr();
      drive(1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2);
      after_edge();
      checks++;
      if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'd1) begin
         failures++; $display("FAIL same_first got we=%b a=%0d d=%h exp we=1 a=9 d=1", WE3, A3, WD3);
      end
      drive(1'b0, '0, '0, 1'b1, 5'd9, 32'd2);
      after_edge();
      checks++;
      if (WE3 !== 1'b1 || A3 !== 5'd9 || WD3 !== 32'd2) begin
         failures++; $display("FAIL same_second got we=%b a=%0d d=%h exp we=1 a=9 d=2", WE3, A3, WD3);
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      after_edge();
   endtask

   task automatic test_force_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, AW'(i + 2), 32'(i), 1'b1, 5'd12, 32'hC0);
         after_edge();
      end
      rst = 1'b1;
      drive(1'b1, 5'd2, 32'hF0, 1'b1, 5'd12, 32'hC0);
      checks++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
         failures++; $display("FAIL force_rst_ready got r0=%b r1=%b exp 0 0", p0_ready, p1_ready);
      end
      after_edge();
      drive(1'b1, 5'd2, 32'hF0, 1'b1, 5'd12, 32'hC0);
      rst = 1'b0;
      #1;
      checks++;
      if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
         failures++; $display("FAIL force_rst_p0_wins got r0=%b r1=%b exp r0=1 r1=0", p0_ready, p1_ready);
      end
      after_edge();
      checks++;
      if (WE3 !== 1'b1 || A3 !== 5'd2 || WD3 !== 32'hF0) begin
         failures++; $display("FAIL force_rst_write got we=%b a=%0d d=%h exp we=1 a=2 d=f0", WE3, A3, WD3);
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      after_edge();
   endtask

   // Model: port 1 gets priority once its current run of denials reaches MAX_WAIT
   task automatic test_random();
      int            streak;
      logic          m_we, m_cf;
      logic [AW-1:0] m_a;
      logic [DW-1:0] m_d;
      logic          pend0, pend1, nz0, nz1, g0, g1, er0, er1;
      logic [AW-1:0] ra0, ra1;
      logic [DW-1:0] rd0, rd1;
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      after_edge();
      streak = 0; m_we = 1'b0; m_cf = 1'b0; m_a = '0; m_d = '0;
      pend0 = 1'b0; pend1 = 1'b0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!pend0 && $urandom_range(0, 2) != 0) begin
            pend0 = 1'b1;
            ra0 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            rd0 = $urandom;
         end
         if (!pend1 && $urandom_range(0, 2) != 0) begin
            pend1 = 1'b1;
            ra1 = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            rd1 = $urandom;
         end
         if (pend1 && $urandom_range(0, 39) == 0) pend1 = 1'b0;
         drive(pend0, ra0, rd0, pend1, ra1, rd1);
         rst = 1'b0;
         #1;
         nz0 = pend0 && (ra0 != '0);
         nz1 = pend1 && (ra1 != '0);
         g1  = nz1 && (!nz0 || streak >= int'(MW));
         g0  = nz0 && !g1;
         er0 = pend0 && ((ra0 == '0) || g0);
         er1 = pend1 && ((ra1 == '0) || g1);
         checks++;
         if (p0_ready !== er0 || p1_ready !== er1) begin
            failures++; $display("FAIL rand_ready it=%0d got r0=%b r1=%b exp r0=%b r1=%b", i, p0_ready, p1_ready, er0, er1);
         end
         m_cf = nz0 && nz1;
         m_we = g0 || g1;
         if (g1) begin m_a = ra1; m_d = rd1; end
         else if (g0) begin m_a = ra0; m_d = rd0; end
         streak = (!pend1 || er1) ? 0 : streak + 1;
         if (er0) pend0 = 1'b0;
         if (er1) pend1 = 1'b0;
         after_edge();
         checks++;
         if (WE3 !== m_we || A3 !== m_a || WD3 !== m_d || conflict !== m_cf) begin
            failures++;
            $display("FAIL rand_out it=%0d got we=%b a=%0d d=%h cf=%b exp we=%b a=%0d d=%h cf=%b",
                     i, WE3, A3, WD3, conflict, m_we, m_a, m_d, m_cf);
         end
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      after_edge();
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1;
      p0_valid = 1'b0; p0_addr = '0; p0_data = '0;
      p1_valid = 1'b0; p1_addr = '0; p1_data = '0;
      checks = 0; failures = 0;
      test_reset();
      test_p0_alone();
      test_starvation();
      test_zero_addr();
      test_same_addr();
      test_force_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rf_write_arbiter
